// File: rtl/sys_onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the on-chip RAM port.
// The arbiter uses the slave modport; the master-side environment uses the master modport.
interface sys_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic              freeze;

  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_write;
  logic [BE_W-1:0]   m0_byteenable;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [BE_W-1:0]   m1_byteenable;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  freeze,
    input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output freeze,
    output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/sys_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency on-chip RAM port between an
// instruction-fetch master (m0) and a data master (m1).

module sys_onchip_mem_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              rd,
  input  logic              wr,
  input  logic              gnt,
  input  logic              rd_hit,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              req,
  output logic              waitrequest,
  output logic              readdatavalid,
  output logic [DATA_W-1:0] readdata
);
  assign req           = rd | wr;
  assign waitrequest   = ~gnt;
  assign readdatavalid = rd_hit;
  assign readdata      = rd_hit ? mem_readdata : '0;
endmodule

module sys_onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  sys_onchip_mem_arbiter_if.slave   bus
);
  localparam int NUM_M = 2;

  logic [NUM_M-1:0]             rd, wr, req, gnt, rd_hit, wait_v, rdv_v;
  logic [NUM_M-1:0][ADDR_W-1:0] addr;
  logic [NUM_M-1:0][BE_W-1:0]   be;
  logic [NUM_M-1:0][DATA_W-1:0] wdata, rdata_v;
  logic                         last_grant, win, any_gnt, rd_valid, rd_owner;

  assign rd    = {bus.m1_read,       bus.m0_read};
  assign wr    = {bus.m1_write,      bus.m0_write};
  assign addr  = {bus.m1_address,    bus.m0_address};
  assign be    = {bus.m1_byteenable, bus.m0_byteenable};
  assign wdata = {bus.m1_writedata,  bus.m0_writedata};

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign rd_hit[i] = rd_valid & (rd_owner == 1'(i));
    sys_onchip_mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .rd            (rd[i]),
      .wr            (wr[i]),
      .gnt           (gnt[i]),
      .rd_hit        (rd_hit[i]),
      .mem_readdata  (bus.mem_readdata),
      .req           (req[i]),
      .waitrequest   (wait_v[i]),
      .readdatavalid (rdv_v[i]),
      .readdata      (rdata_v[i])
    );
  end

  assign bus.m0_waitrequest   = wait_v[0];
  assign bus.m1_waitrequest   = wait_v[1];
  assign bus.m0_readdatavalid = rdv_v[0];
  assign bus.m1_readdatavalid = rdv_v[1];
  assign bus.m0_readdata      = rdata_v[0];
  assign bus.m1_readdata      = rdata_v[1];

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    win = 1'b0;
    gnt = '0;
    if (!reset && !bus.freeze) begin
      win = (req[0] & req[1]) ? ~last_grant : req[1];
      gnt = req[win] ? (NUM_M'(1) << win) : '0;
    end
  end

  assign any_gnt = |gnt;

  assign bus.mem_address    = any_gnt ? addr[win]  : '0;
  assign bus.mem_byteenable = any_gnt ? be[win]    : '0;
  assign bus.mem_writedata  = any_gnt ? wdata[win] : '0;
  assign bus.mem_chipselect = any_gnt;
  assign bus.mem_write      = any_gnt & wr[win];
  assign bus.mem_clken      = ~bus.freeze & ~reset;

  // Read+write together is a write, so only a pure read earns a return beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (any_gnt) last_grant <= win;
      rd_valid <= any_gnt & ~wr[win];
      rd_owner <= win;
    end
  end
endmodule

// File: tb/tb_sys_onchip_mem_arbiter.sv
// Randomized scoreboard bench: a high-level arbitration/RAM model predicts grants and
// read returns; a negedge monitor pops expected read beats and compares.
module tb_sys_onchip_mem_arbiter;
  localparam int ADDR_W = 13, DATA_W = 32, BE_W = 4, DEPTH = 8192;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] d;
  } req_t;

  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  sys_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  sys_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM attached to the DUT's port: registered read, byte-masked write, gated by clken.
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_q = '0;
  assign bus.mem_readdata = ram_q;
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_address];
      end
    end
  end

  // Reference state
  logic [31:0] shadow [DEPTH];
  exp_t        q[$];
  req_t        rq[2];
  bit          frz = 0;
  bit          rst_v = 1;
  int          last = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: a read beat is due exactly one cycle after its grant, to its owner only.
  always @(negedge clk) begin
    bit          v0, v1;
    logic [31:0] d0, d1;
    v0 = 0; v1 = 0; d0 = '0; d1 = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.owner == 0) begin v0 = 1; d0 = e.data; end
      else              begin v1 = 1; d1 = e.data; end
    end
    chk("m0_readdatavalid", 64'(bus.m0_readdatavalid), 64'(v0));
    chk("m1_readdatavalid", 64'(bus.m1_readdatavalid), 64'(v1));
    chk("m0_readdata", 64'(bus.m0_readdata), 64'(d0));
    chk("m1_readdata", 64'(bus.m1_readdata), 64'(d1));
  end

  task automatic apply();
    bus.m0_read = rq[0].rd; bus.m0_write = rq[0].wr; bus.m0_address = rq[0].a;
    bus.m0_byteenable = rq[0].be; bus.m0_writedata = rq[0].d;
    bus.m1_read = rq[1].rd; bus.m1_write = rq[1].wr; bus.m1_address = rq[1].a;
    bus.m1_byteenable = rq[1].be; bus.m1_writedata = rq[1].d;
    bus.freeze = frz;
    reset = rst_v;
    if (rst_v) begin
      q.delete();
      last = 1;
    end
  endtask

  // One bus cycle: drive, predict the grant from the arbitration rules, check the
  // RAM-side view, then commit the transfer into the reference.
  task automatic cycle();
    int   g;
    bit   r0, r1;
    req_t w;
    apply();
    @(negedge clk);
    g  = -1;
    r0 = rq[0].rd | rq[0].wr;
    r1 = rq[1].rd | rq[1].wr;
    if (!rst_v && !frz) begin
      if (r0 && r1) g = (last == 0) ? 1 : 0;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
    end
    w = (g >= 0) ? rq[g] : '0;
    chk("m0_waitrequest", 64'(bus.m0_waitrequest), 64'(g != 0));
    chk("m1_waitrequest", 64'(bus.m1_waitrequest), 64'(g != 1));
    chk("mem_chipselect", 64'(bus.mem_chipselect), 64'(g >= 0));
    chk("mem_write", 64'(bus.mem_write), 64'(g >= 0 && w.wr));
    chk("mem_address", 64'(bus.mem_address), 64'(w.a));
    chk("mem_byteenable", 64'(bus.mem_byteenable), 64'(w.be));
    chk("mem_writedata", 64'(bus.mem_writedata), 64'(w.d));
    chk("mem_clken", 64'(bus.mem_clken), 64'(!frz && !rst_v));
    if (g >= 0) begin
      last = g;
      if (w.wr) begin
        for (int b = 0; b < 4; b++)
          if (w.be[b]) shadow[w.a][8*b +: 8] = w.d[8*b +: 8];
      end else begin
        q.push_back('{due: cyc + 1, owner: g, data: shadow[w.a]});
      end
      rq[g] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk(bit rd, bit wr, logic [ADDR_W-1:0] a, logic [3:0] be, logic [31:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.a = a; r.be = be; r.d = d;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'h5A00_0000 ^ (i * 32'h0001_0101);
      shadow[i] = 32'h5A00_0000 ^ (i * 32'h0001_0101);
    end
    ram[13'h010] = 32'hDEADBEEF; shadow[13'h010] = 32'hDEADBEEF;
    ram[13'h100] = 32'hAAAAAAAA; shadow[13'h100] = 32'hAAAAAAAA;
    rq[0] = '0; rq[1] = '0;
    rst_v = 1;
    apply();
    repeat (3) cycle();
    rst_v = 0;

    // Single m0 read, data back next cycle
    rq[0] = mk(1, 0, 13'h010, 4'hF, 32'h0);
    cycle();
    cycle();

    // m0 read accepted, then reset pulse discards its return
    rq[0] = mk(1, 0, 13'h011, 4'hF, 32'h0);
    cycle();
    rst_v = 1;
    cycle();
    rst_v = 0;

    // Both masters read every cycle: first contention goes to m0, then alternate
    for (int k = 0; k < 6; k++) begin
      if (!rq[0].rd) rq[0] = mk(1, 0, 13'(k), 4'hF, 32'h0);
      if (!rq[1].rd) rq[1] = mk(1, 0, 13'(32 + k), 4'hF, 32'h0);
      cycle();
    end
    while (rq[0].rd || rq[1].rd) cycle();
    cycle();

    // Partial write then read back
    rq[1] = mk(0, 1, 13'h100, 4'b0011, 32'h12345678);
    cycle();
    rq[1] = mk(1, 0, 13'h100, 4'hF, 32'h0);
    cycle();
    cycle();

    // Read+write together is a write; zero-byteenable write leaves RAM intact
    rq[1] = mk(1, 1, 13'h005, 4'hF, 32'hCAFEF00D);
    cycle();
    rq[0] = mk(0, 1, 13'h006, 4'h0, 32'hFFFFFFFF);
    cycle();
    rq[0] = mk(1, 0, 13'h006, 4'hF, 32'h0);
    cycle();
    rq[1] = mk(1, 0, 13'h005, 4'hF, 32'h0);
    cycle();
    cycle();

    // Freeze for 3 cycles with m0 pending, including one read in flight
    rq[0] = mk(1, 0, 13'h010, 4'hF, 32'h0);
    cycle();
    rq[0] = mk(1, 0, 13'h007, 4'hF, 32'h0);
    frz = 1;
    repeat (3) cycle();
    frz = 0;
    cycle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(rq[m].rd || rq[m].wr) && $urandom_range(0, 9) < 6) begin
          int               kind;
          logic [ADDR_W-1:0] a;
          kind = $urandom_range(0, 9);
          a = ($urandom_range(0, 4) == 0) ? 13'h100 : 13'($urandom_range(0, 15));
          rq[m] = mk(kind < 6 || kind == 9, kind >= 6, a, 4'($urandom_range(0, 15)), $urandom);
        end
      end
      frz   = ($urandom_range(0, 9) == 0);
      rst_v = ($urandom_range(0, 49) == 0);
      cycle();
    end
    frz = 0; rst_v = 0;
    rq[0] = '0; rq[1] = '0;
    repeat (3) cycle();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sys_onchip_mem_arbiter.md
Name: sys_onchip_mem_arbiter

Overview:
- Shares one 32-bit port of the 8192-word on-chip RAM between two Avalon-MM masters: m0 (RISC-V instruction fetch) and m1 (RISC-V data/LSU).
- Round-robin arbitration; one transfer accepted per cycle.
- Drives the RAM port signals: address, byteenable, chipselect, write, writedata, clken.
- Routes the 1-cycle-latency read data back to whichever master issued the read.

Parameters:
- ADDR_W, 13, word address width of the RAM port.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- freeze  in  1  stall: no new grants while high.
- m0_address  in  ADDR_W  master 0 word address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same seven signals and meanings as m0_*, for master 1.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  RAM read data; valid one cycle after address.

Behaviour:
- Request: mX_req = mX_read | mX_write.
- Read and write asserted together: treated as a write; the read is ignored.
- Grant (combinational, same cycle):
  - No grant while freeze or reset is high.
  - Only one master requesting: that master is granted.
  - Both requesting: the master that is not last_grant is granted.
- last_grant register:
  - Reset value 1, so m0 wins the first contention.
  - Updated on every accepted transfer to the granted master.
- mX_waitrequest = ~(grant to X). It is 1 whenever reset is high and whenever mX_req is 0.
- A transfer is accepted when mX_req=1 and mX_waitrequest=0. The master must hold all inputs stable while waitrequest is high.
- RAM port muxing (combinational from the winner):
  - mem_address, mem_byteenable, mem_writedata come from the winner; all zero when there is no grant.
  - mem_chipselect = any grant.
  - mem_write = grant & winner write.
  - mem_clken = ~freeze & ~reset.
- Read return path:
  - Registers rd_valid (reset 0) and rd_owner (reset 0) are loaded on every clk edge.
  - rd_valid <= accepted read; rd_owner <= winner index.
  - mX_readdatavalid = rd_valid & (rd_owner==X).
  - mX_readdata = mem_readdata when valid, else 0.
  - Latency: read accepted in cycle N gives readdatavalid in cycle N+1. Back-to-back reads give one valid per cycle, in issue order.
- Writes: 0-cycle acceptance; no response.
- byteenable == 0 on a write: still accepted and issued with mem_write=1; the RAM is unchanged.
- freeze asserted while a read is outstanding: rd_valid still delivers in the next cycle, because the RAM output is not gated by clken on the data path.
- Reset asserted mid-operation: rd_valid and rd_owner clear immediately (async), pending read data is discarded, last_grant returns to 1.
- Reset values of all outputs: waitrequest 1; readdatavalid 0; readdata 0; mem_* 0.
- Single-requester throughput: 1 transfer/cycle. Two continuous requesters alternate every cycle.
- No address decode; no bursts; no lock/hold.

Test Plan:
- After reset deassert, m0 read addr 0x0010 (RAM holds 0xDEADBEEF) -> m0_waitrequest=0 same cycle, m0_readdatavalid=1 with 0xDEADBEEF next cycle, m1_readdatavalid=0.
- m0 and m1 both request reads every cycle for 6 cycles -> grants ordered m0,m1,m0,m1,m0,m1; each readdatavalid pulses one cycle after its grant with the correct data.
- m1 write 0x0100 data 0x12345678 be=4'b0011, then m1 read 0x0100 (prior content 0xAAAAAAAA) -> readdata 0xAAAA5678.
- m1 asserts read and write together to 0x0005 -> mem_write=1, no readdatavalid on either master.
- freeze high for 3 cycles with m0 requesting -> m0_waitrequest=1 and mem_chipselect=0 for 3 cycles, mem_clken=0; m0 is granted on the first cycle after freeze drops.
- Reset pulsed the cycle after an m0 read is accepted -> m0_readdatavalid stays 0, all waitrequest=1 during reset, first post-reset contention is won by m0.
